qam16_coherent_demod: RTL and testbench
=======================================

Name: qam16_coherent_demod

Overview:
- Receive-side counterpart of the 8-phase carrier generator.
- Correlates a real passband sample stream against the same 8-entry cos/sin carrier, integrating over CYCLES carrier periods per symbol.
- Slices the I/Q integrals into one Gray-coded 16QAM symbol per symbol period.
- Sits between the sample source (ADC model or channel loopback) and the symbol de-mapper.

Parameters:
- CYCLES, 1, carrier periods (8 samples each) per symbol; must be ≥1.
- THRESH, 16384, outer/inner decision threshold per carrier period. Effective threshold = THRESH*CYCLES.
- ACC_W, 20+$clog2(CYCLES), signed accumulator width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_sample valid this cycle.
- in_sample  in  8  signed passband sample.
- sync  in  1  qualified by in_valid: this sample is carrier phase 0 and the first sample of a new symbol.
- sym_valid  out  1  one-cycle pulse; sym/acc outputs updated.
- sym  out  4  {I bits, Q bits}, Gray coded.
- sym_i_acc  out  ACC_W  signed I correlation of the last symbol.
- sym_q_acc  out  ACC_W  signed Q correlation of the last symbol.

Behaviour:
- Reset (async assert, sync release): phase=0, sample count=0, both accumulators=0, all pipeline valid flags=0, sym_valid=0, sym=0, sym_i_acc=0, sym_q_acc=0.
- Carrier tables, indexed by phase 0..7:
  - cos = 127,91,0,-91,-128,-91,0,91
  - sin = 0,91,127,91,0,-91,-128,-91
- Phase and sample counter advance only on accepted samples (in_valid=1).
  - Phase wraps 7→0.
  - Sample count wraps at 8*CYCLES-1→0.
  - The sample with count 8*CYCLES-1 is tagged "last".
- sync & in_valid: that sample uses phase 0 and count 0 and is tagged "first". The counters continue from it. A partial symbol in progress is discarded and produces no output. sync without in_valid is ignored.
- Pipeline (no stalls; flags advance every clk):
  - S1: register x*cos[phase] and x*sin[phase] (16-bit signed, exact; -128*-128=16384 fits), with first/last/valid flags.
  - S2: if first, acc <= product; else acc <= acc + product. Accumulators hold when S1 is not valid.
  - S3: on a valid last sample, register the final sums, slice them and pulse sym_valid.
- Latency: the last sample is accepted at edge E; sym/sym_*_acc update and sym_valid=1 at edge E+3 for exactly one cycle. This is independent of in_valid gaps after E.
- Slicer, per axis, with T = THRESH*CYCLES:
  - acc ≥ T → +3 → bits 10
  - 0 ≤ acc < T → +1 → bits 11
  - -T ≤ acc < 0 → -1 → bits 01
  - acc < -T → -3 → bits 00
  - Ties go toward the higher level: acc==0 gives +1, acc==T gives +3, acc==-T gives -1.
- Overflow: ACC_W covers 8*CYCLES*16384 with sign, so no saturation logic is required.
- Back-to-back symbols: a first sample at E+1 after a last at E is legal. The S2 restart and the S3 capture must not interfere.
- Reset mid-symbol clears all state. Any in-flight symbol is lost and no sym_valid is produced.

Decomposition:
- Package qam16_pkg holds:
  - the cos/sin carrier constant arrays
  - the sample width (8) and product width (16)
  - the Gray level encoding constants (LVL_M3=2'b00, LVL_M1=2'b01, LVL_P1=2'b11, LVL_P3=2'b10)
  - a slice function (acc, T → 2 bits)
- Sub-module carrier_lut: combinational, phase[2:0] → cos, sin. Reused by later blocks.

Test Plan:
- CYCLES=1, no sync after reset. Stream 48,34,0,-34,-48,-34,0,34 continuously → I=24616, Q=0, sym=4'b1011, sym_valid 3 edges after the 8th sample.
- Stream 0,34,48,34,0,-34,-48,-34 → I=0, Q=24616, sym=4'b1110. Repeat back-to-back for 4 symbols → four single-cycle pulses exactly 8 cycles apart.
- Stream -16,-11,0,11,16,11,0,-11 → I=-8084, Q=0, sym=4'b0111. Insert random in_valid gaps → identical values; pulse 3 edges after the last accepted sample.
- Boundaries: force the I sum to exactly 16384 → I bits 10; to -16384 → 01; to -16385 → 00. Check at CYCLES=1 and at CYCLES=4 (T=65536).
- Assert sync at sample 5 of a symbol → no output for the aborted symbol. The next output equals the correlation of the 8 samples starting at the sync sample.
- Assert rst_n low mid-symbol → all outputs 0 immediately with no clk edge. After release, the first symbol decodes correctly.

Source files
------------

// File: rtl/qam16_pkg.sv
// Shared constants for the 16QAM coherent receive path: carrier tables,
// datapath widths, Gray level codes and the per-axis slicer.
package qam16_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned PROD_W   = 16;
  localparam int unsigned SLICE_W  = 32;

  localparam logic signed [SAMPLE_W-1:0] COS_TBL [8] = '{
    8'sd127, 8'sd91, 8'sd0, -8'sd91, 8'sh80, -8'sd91, 8'sd0, 8'sd91
  };
  localparam logic signed [SAMPLE_W-1:0] SIN_TBL [8] = '{
    8'sd0, 8'sd91, 8'sd127, 8'sd91, 8'sd0, -8'sd91, 8'sh80, -8'sd91
  };

  localparam logic [1:0] LVL_M3 = 2'b00;
  localparam logic [1:0] LVL_M1 = 2'b01;
  localparam logic [1:0] LVL_P1 = 2'b11;
  localparam logic [1:0] LVL_P3 = 2'b10;

  // Boundary values resolve toward the higher level.
  function automatic logic [1:0] qam_slice(input logic signed [SLICE_W-1:0] acc,
                                           input logic signed [SLICE_W-1:0] thr);
    logic [1:0] lvl;
    lvl = LVL_M3;
    if (acc >= thr)       lvl = LVL_P3;
    else if (acc >= 0)    lvl = LVL_P1;
    else if (acc >= -thr) lvl = LVL_M1;
    return lvl;
  endfunction

endpackage

// File: rtl/carrier_lut.sv
// Combinational 8-phase cos/sin carrier lookup.
module carrier_lut
  import qam16_pkg::*;
(
  input  logic        [2:0]          i_phase,
  output logic signed [SAMPLE_W-1:0] o_cos_c,
  output logic signed [SAMPLE_W-1:0] o_sin_c
);

  assign o_cos_c = COS_TBL[i_phase];
  assign o_sin_c = SIN_TBL[i_phase];

endmodule

// File: rtl/qam16_coherent_demod.sv
// Correlates a passband sample stream against the 8-phase carrier over
// CYCLES periods and slices the I/Q integrals into a Gray-coded 16QAM symbol.
module qam16_coherent_demod
  import qam16_pkg::*;
#(
  parameter int unsigned CYCLES = 1,
  parameter int unsigned THRESH = 16384,
  parameter int unsigned ACC_W  = 20 + $clog2(CYCLES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       sync,
  output logic                       sym_valid,
  output logic        [3:0]          sym,
  output logic signed [ACC_W-1:0]    sym_i_acc,
  output logic signed [ACC_W-1:0]    sym_q_acc
);

  localparam int unsigned SPS   = 8 * CYCLES;
  localparam int unsigned CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
  localparam logic signed [SLICE_W-1:0] THR = SLICE_W'(THRESH * CYCLES);

  logic        [CNT_W-1:0]    r_cnt;
  logic        [CNT_W-1:0]    w_cnt;
  logic signed [SAMPLE_W-1:0] w_cos;
  logic signed [SAMPLE_W-1:0] w_sin;
  logic signed [PROD_W-1:0]   w_prod_i;
  logic signed [PROD_W-1:0]   w_prod_q;

  logic                       r_s1_valid;
  logic                       r_s1_first;
  logic                       r_s1_last;
  logic signed [PROD_W-1:0]   r_s1_prod_i;
  logic signed [PROD_W-1:0]   r_s1_prod_q;
  logic signed [ACC_W-1:0]    r_acc_i;
  logic signed [ACC_W-1:0]    r_acc_q;
  logic                       r_s2_done;
  logic                       r_s3_valid;
  logic signed [ACC_W-1:0]    r_fin_i;
  logic signed [ACC_W-1:0]    r_fin_q;

  // A symbol is a whole number of carrier periods, so the phase is the count mod 8.
  assign w_cnt = sync ? '0 : r_cnt;

  carrier_lut u_lut (
    .i_phase (w_cnt[2:0]),
    .o_cos_c (w_cos),
    .o_sin_c (w_sin)
  );

  assign w_prod_i = PROD_W'(in_sample) * PROD_W'(w_cos);
  assign w_prod_q = PROD_W'(in_sample) * PROD_W'(w_sin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (in_valid) begin
      r_cnt <= (w_cnt == CNT_LAST) ? '0 : w_cnt + 1'b1;
    end
  end

  // S1: carrier products and symbol boundary tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_prod_i <= '0;
      r_s1_prod_q <= '0;
    end else begin
      r_s1_valid  <= in_valid;
      r_s1_first  <= (w_cnt == '0);
      r_s1_last   <= (w_cnt == CNT_LAST);
      r_s1_prod_i <= w_prod_i;
      r_s1_prod_q <= w_prod_q;
    end
  end

  // S2: integrate; the first sample of a symbol restarts the sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      r_s2_done <= 1'b0;
    end else begin
      r_s2_done <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        r_acc_i <= r_s1_first ? ACC_W'(r_s1_prod_i) : r_acc_i + ACC_W'(r_s1_prod_i);
        r_acc_q <= r_s1_first ? ACC_W'(r_s1_prod_q) : r_acc_q + ACC_W'(r_s1_prod_q);
      end
    end
  end

  // S3: capture completed sums before the next symbol overwrites the accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s3_valid <= 1'b0;
      r_fin_i    <= '0;
      r_fin_q    <= '0;
    end else begin
      r_s3_valid <= r_s2_done;
      if (r_s2_done) begin
        r_fin_i <= r_acc_i;
        r_fin_q <= r_acc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_valid <= 1'b0;
      sym       <= '0;
      sym_i_acc <= '0;
      sym_q_acc <= '0;
    end else begin
      sym_valid <= r_s3_valid;
      if (r_s3_valid) begin
        sym       <= {qam_slice(SLICE_W'(r_fin_i), THR), qam_slice(SLICE_W'(r_fin_q), THR)};
        sym_i_acc <= r_fin_i;
        sym_q_acc <= r_fin_q;
      end
    end
  end

endmodule

// File: tb/tb_qam16_coherent_demod.sv
// Directed bench for qam16_coherent_demod at CYCLES=1 and CYCLES=4 with
// hand-computed correlations, pulse timing and slicer boundaries.
module tb_qam16_coherent_demod;

  typedef struct {
    int cyc;
    int sym;
    int iv;
    int qv;
  } pulse_t;
  typedef int pat_t [8];

  localparam pat_t PA  = '{48, 34, 0, -34, -48, -34, 0, 34};
  localparam pat_t PB  = '{0, 34, 48, 34, 0, -34, -48, -34};
  localparam pat_t PC  = '{-16, -11, 0, 11, 16, 11, 0, -11};
  localparam pat_t PP  = '{0, 0, 0, 0, -128, 0, 0, 0};
  localparam pat_t PN  = '{-128, 0, 0, 0, 1, 0, 0, 0};
  localparam pat_t PN1 = '{-127, 0, 0, 0, 2, 0, 0, 0};

  logic               clk   = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid [2];
  logic               sync [2];
  logic signed [7:0]  in_sample [2];
  logic               sv1, sv4;
  logic        [3:0]  sym1, sym4;
  logic signed [19:0] ia1, qa1;
  logic signed [21:0] ia4, qa4;

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;
  int last_cyc [2];
  int txq [$];
  pulse_t obs0 [$];
  pulse_t obs1 [$];
  pulse_t exp0 [$];
  pulse_t exp1 [$];

  qam16_coherent_demod #(.CYCLES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_sample (in_sample[0]),
    .sync      (sync[0]),
    .sym_valid (sv1),
    .sym       (sym1),
    .sym_i_acc (ia1),
    .sym_q_acc (qa1)
  );

  qam16_coherent_demod #(.CYCLES(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_sample (in_sample[1]),
    .sync      (sync[1]),
    .sym_valid (sv4),
    .sym       (sym4),
    .sym_i_acc (ia4),
    .sym_q_acc (qa4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse with the index of the edge that produced it.
  always @(negedge clk) begin
    if (sv1) obs0.push_back('{cyc, int'(sym1), int'(ia1), int'(qa1)});
    if (sv4) obs1.push_back('{cyc, int'(sym4), int'(ia4), int'(qa4)});
  end

  task automatic check(input string tag, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic idle(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid[d]  = 1'b0;
      sync[d]      = 1'(k & 1);
      in_sample[d] = 8'($urandom);
    end
  endtask

  task automatic put(input int d, input int x, input bit s, input int gap);
    if (gap > 0) idle(d, gap);
    @(negedge clk);
    in_valid[d]  = 1'b1;
    sync[d]      = s;
    in_sample[d] = 8'(x);
    last_cyc[d]  = cyc + 1;
  endtask

  task automatic load(input pat_t p, input int reps);
    for (int r = 0; r < reps; r++)
      for (int k = 0; k < 8; k++) txq.push_back(p[k]);
  endtask

  task automatic send(input int d, input bit s0, input int gap_max);
    foreach (txq[k]) put(d, txq[k], s0 && (k == 0), int'($urandom_range(0, gap_max)));
    txq.delete();
  endtask

  task automatic expect_sym(input int d, input int s, input int iv, input int qv);
    pulse_t p;
    p.cyc = last_cyc[d] + 3;
    p.sym = s;
    p.iv  = iv;
    p.qv  = qv;
    if (d == 0) exp0.push_back(p);
    else        exp1.push_back(p);
  endtask

  task automatic compare(input int d, input string tag);
    pulse_t o [$];
    pulse_t e [$];
    idle(d, 6);
    if (d == 0) begin
      o = obs0; e = exp0; obs0.delete(); exp0.delete();
    end else begin
      o = obs1; e = exp1; obs1.delete(); exp1.delete();
    end
    check({tag, ".count"}, o.size(), e.size());
    for (int k = 0; k < e.size() && k < o.size(); k++) begin
      check($sformatf("%s[%0d].cycle", tag, k), o[k].cyc, e[k].cyc);
      check($sformatf("%s[%0d].sym", tag, k), o[k].sym, e[k].sym);
      check($sformatf("%s[%0d].i_acc", tag, k), o[k].iv, e[k].iv);
      check($sformatf("%s[%0d].q_acc", tag, k), o[k].qv, e[k].qv);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      sync[d]      = 1'b0;
      in_sample[d] = '0;
    end
    #1 rst_n = 1'b0;
    #11;
    check("reset.sym_valid", sv1, 0);
    check("reset.sym", sym1, 0);
    check("reset.i_acc", ia1, 0);
    check("reset.q_acc", qa1, 0);
    check("reset.sym_valid4", sv4, 0);
    @(negedge clk) rst_n = 1'b1;

    // CYCLES=1, no sync: one I symbol then four back-to-back Q symbols
    load(PA, 1); send(0, 1'b0, 0); expect_sym(0, 4'b1011, 24616, 0);
    repeat (4) begin
      load(PB, 1); send(0, 1'b0, 0); expect_sym(0, 4'b1110, 0, 24616);
    end
    compare(0, "b2b");

    load(PC, 1); send(0, 1'b0, 3); expect_sym(0, 4'b0111, -8084, 0);
    load(PC, 1); send(0, 1'b0, 3); expect_sym(0, 4'b0111, -8084, 0);
    compare(0, "gaps");

    load(PP, 1);  send(0, 1'b0, 0); expect_sym(0, 4'b1011, 16384, 0);
    load(PN, 1);  send(0, 1'b0, 1); expect_sym(0, 4'b0111, -16384, 0);
    load(PN1, 1); send(0, 1'b0, 0); expect_sym(0, 4'b0011, -16385, 0);
    compare(0, "bound1");

    // Abort after five samples; the sync sample starts a fresh symbol
    for (int k = 0; k < 5; k++) txq.push_back(PA[k]);
    send(0, 1'b0, 0);
    load(PB, 1); send(0, 1'b1, 0); expect_sym(0, 4'b1110, 0, 24616);
    compare(0, "sync_abort");

    // Reset between last-sample acceptance and its output pulse
    load(PA, 1); send(0, 1'b0, 0);
    @(posedge clk);
    #2;
    check("pre_rst.sym", sym1, 4'b1110);
    check("pre_rst.q_acc", qa1, 24616);
    rst_n = 1'b0;
    in_valid[0] = 1'b0;
    #1;
    check("rst_mid.sym_valid", sv1, 0);
    check("rst_mid.sym", sym1, 0);
    check("rst_mid.i_acc", ia1, 0);
    check("rst_mid.q_acc", qa1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load(PA, 1); send(0, 1'b0, 0); expect_sym(0, 4'b1011, 24616, 0);
    compare(0, "after_rst");

    // CYCLES=4, threshold 65536
    load(PP, 4); send(1, 1'b0, 1); expect_sym(1, 4'b1011, 65536, 0);
    load(PN, 4); send(1, 1'b0, 0); expect_sym(1, 4'b0111, -65536, 0);
    load(PN, 3); load(PN1, 1); send(1, 1'b0, 0); expect_sym(1, 4'b0011, -65537, 0);
    load(PB, 4); send(1, 1'b0, 0); expect_sym(1, 4'b1110, 0, 98464);
    compare(1, "cyc4");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
